// File: rtl/cceip_mm_read_stream.sv
// AXI4 read master that turns a (base, size) job into 4 KB-safe bursts and
// replays the returned data as a 64-bit AXI-Stream with tlast on the final beat.
module cceip_mm_read_stream #(
    parameter int BURST_LEN       = 16,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        ap_clk,
    input  logic        areset,
    input  logic        read_start,
    output logic        read_done,
    output logic        read_error,
    input  logic [63:0] read_base_addr,
    input  logic [63:0] read_size,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [63:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [63:0] m_axi_rdata,
    input  logic        m_axi_rlast,
    input  logic [1:0]  m_axi_rresp,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [63:0] m_axis_tdata,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on any rising edge where valid && ready;
    // valid never waits on ready, and payload is held while valid && !ready.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [8:0]    BL      = 9'(BURST_LEN);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   left_q, left_d;
    logic [63:0]   total_q, total_d;
    logic [63:0]   out_idx_q, out_idx_d;
    logic          arvalid_q, arvalid_d;
    logic [63:0]   araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic          err_q, err_d;
    logic [CW-1:0] rsv_q, rsv_d;
    logic [OW-1:0] outst_q, outst_d;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q;

    logic          ar_hs, r_hs, s_hs;
    logic [8:0]    hs_len_c;
    logic [63:0]   total_c;
    logic [63:0]   cur_addr_c;
    logic [63:0]   cur_left_c;
    logic [12:0]   page_beats_c;
    logic [8:0]    burst_len_c;
    logic [31:0]   free_c;
    logic          issue_ok_c;

    assign m_axi_rready  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign ar_hs         = arvalid_q && m_axi_arready;
    assign r_hs          = m_axi_rvalid && m_axi_rready;
    assign m_axis_tvalid = (fifo_cnt_q != '0);
    assign s_hs          = m_axis_tvalid && m_axis_tready;
    assign hs_len_c      = {1'b0, arlen_q} + 9'd1;
    assign total_c       = (read_size + 64'd7) >> 3;

    // In IDLE the first burst is sized straight from the job inputs so the
    // first AR is already registered on the cycle after read_start.
    assign cur_addr_c = (state_q == S_IDLE) ? read_base_addr : addr_q;
    assign cur_left_c = (state_q == S_IDLE) ? total_c : left_q;

    always_comb begin
        page_beats_c = (13'h1000 - {1'b0, cur_addr_c[11:0]}) >> 3;
        burst_len_c  = BL;
        if ({4'd0, burst_len_c} > page_beats_c) begin
            burst_len_c = page_beats_c[8:0];
        end
        if (cur_left_c < {55'd0, burst_len_c}) begin
            burst_len_c = cur_left_c[8:0];
        end
    end

    assign free_c     = 32'(FIFO_DEPTH) - 32'(fifo_cnt_q) - 32'(rsv_q);
    assign issue_ok_c = (cur_left_c != 64'd0) && (outst_q < OUT_MAX) &&
                        (free_c >= {23'd0, burst_len_c});

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        left_d    = left_q;
        total_d   = total_q;
        out_idx_d = out_idx_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        err_d     = err_q;
        rsv_d     = rsv_q + (ar_hs ? CW'(hs_len_c) : CW'(0)) - (r_hs ? CW'(1) : CW'(0));
        outst_d   = outst_q + (ar_hs ? OW'(1) : OW'(0)) - ((r_hs && m_axi_rlast) ? OW'(1) : OW'(0));

        if (r_hs && (m_axi_rresp != 2'b00)) begin
            err_d = 1'b1;
        end
        if (s_hs) begin
            out_idx_d = out_idx_q + 64'd1;
        end
        if (ar_hs) begin
            arvalid_d = 1'b0;
            addr_d    = addr_q + {52'd0, hs_len_c, 3'b000};
            left_d    = left_q - {55'd0, hs_len_c};
        end

        unique case (state_q)
            S_IDLE: begin
                if (read_start) begin
                    total_d   = total_c;
                    addr_d    = read_base_addr;
                    left_d    = total_c;
                    out_idx_d = 64'd0;
                    err_d     = 1'b0;
                    if (total_c == 64'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        if (issue_ok_c) begin
                            arvalid_d = 1'b1;
                            araddr_d  = cur_addr_c;
                            arlen_d   = 8'(burst_len_c - 9'd1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                // Counters settle on the handshake edge, so a new burst is only
                // sized once the previous AR has been accepted.
                if (!arvalid_q) begin
                    if (left_q == 64'd0) begin
                        state_d = S_DRAIN;
                    end else if (issue_ok_c) begin
                        arvalid_d = 1'b1;
                        araddr_d  = cur_addr_c;
                        arlen_d   = 8'(burst_len_c - 9'd1);
                    end
                end
            end
            S_DRAIN: begin
                if ((outst_q == '0) && (rsv_q == '0) && (fifo_cnt_q == '0) &&
                    (out_idx_q == total_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            addr_q    <= 64'd0;
            left_q    <= 64'd0;
            total_q   <= 64'd0;
            out_idx_q <= 64'd0;
            arvalid_q <= 1'b0;
            araddr_q  <= 64'd0;
            arlen_q   <= 8'd0;
            err_q     <= 1'b0;
            rsv_q     <= '0;
            outst_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            total_q   <= total_d;
            out_idx_q <= out_idx_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            err_q     <= err_d;
            rsv_q     <= rsv_d;
            outst_q   <= outst_d;
        end
    end

    // Space is reserved before each AR, so writes never find the FIFO full.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (r_hs) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (s_hs) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + (r_hs ? CW'(1) : CW'(0)) - (s_hs ? CW'(1) : CW'(0));
        end
    end

    always_ff @(posedge ap_clk) begin
        if (r_hs) begin
            mem[wr_ptr_q] <= m_axi_rdata;
        end
    end

    assign m_axis_tdata  = mem[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && (out_idx_q == (total_q - 64'd1));
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b01;
    assign read_done     = (state_q == S_DONE);
    assign read_error    = err_q;
    assign dbg_state     = state_q;

endmodule
